// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter for the singlecycle core
// LSU I/O port. Core stores push bytes into a TX FIFO; a bit-serial FSM shifts
// them out LSB first on o_tx.
//
// Register window (16 bytes at BASE_ADDR, offset = i_addr[3:2]):
//   0x0 TXDATA   (W) push i_st_data[7:0]; reads 0
//   0x4 STATUS   (R) [0] full [1] empty [2] busy [3] overflow [7:4] level
//                    [8] parity enabled; (W) bit3 = 1 clears overflow
//   0x8 BAUD_DIV (RW) [15:0] clocks per bit, 0 treated as 1
//   0xC reserved
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset     synchronous active-high reset
//   i_addr      byte address from the LSU
//   i_st_en     store strobe
//   i_st_data   store data
//   o_ld_data   combinational read data, 0 outside the window
//   o_tx        registered serial line, idle high
//   o_irq_empty registered, 1 when FIFO empty and FSM idle
//
// Build option: define UART_PARITY_EN to insert an even-parity bit between
// data bit 7 and the stop bit (8E1 framing, STATUS[8] reads 1).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_7000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic        i_st_en,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_ld_data,
  output logic        o_tx,
  output logic        o_irq_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef UART_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  localparam logic PARITY_FLAG = 1'b0;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  // Counter reload value for one bit; a divisor of 0 behaves like 1.
  function automatic logic [15:0] period_m1(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : div - 16'd1;
  endfunction

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic          overflow;
  logic [15:0]   baud_div;
  state_t        state, state_n;
  logic [15:0]   baud_cnt, baud_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n, bit_nxt;
  logic [7:0]    shreg, shreg_n;
  logic          tx_q, tx_n;
  logic          irq_q;
  logic          pop, push, full, empty;
  logic          sel, wr_txdata, wr_status, wr_baud;
  logic [1:0]    off;
  logic [3:0]    level;
  logic          unused_bits;

  assign unused_bits = ^{i_addr[1:0], i_st_data[31:16]};

  assign sel       = (i_addr[31:4] == BASE_ADDR[31:4]);
  assign off       = i_addr[3:2];
  assign wr_txdata = i_st_en & sel & (off == 2'd0);
  assign wr_status = i_st_en & sel & (off == 2'd1);
  assign wr_baud   = i_st_en & sel & (off == 2'd2);

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO survives.
  assign push  = wr_txdata & (~full | pop);

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_comb begin
    if (32'(count) > 32'd15) level = 4'hF;
    else                     level = 4'(count);
  end

  assign bit_nxt = bit_idx + 3'd1;

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    tx_n       = tx_q;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          shreg_n    = fifo_mem[rd_ptr];
          state_n    = S_START;
          baud_cnt_n = period_m1(baud_div);
          tx_n       = 1'b0;
        end
      end
      S_START: begin
        if (baud_cnt == 16'd0) begin
          state_n    = S_DATA;
          bit_idx_n  = 3'd0;
          baud_cnt_n = period_m1(baud_div);
          tx_n       = shreg[0];
        end else begin
          baud_cnt_n = baud_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_cnt == 16'd0) begin
          baud_cnt_n = period_m1(baud_div);
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_n = S_PARITY;
            tx_n    = ^shreg;
`else
            state_n = S_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_idx_n = bit_nxt;
            tx_n      = shreg[bit_nxt];
          end
        end else begin
          baud_cnt_n = baud_cnt - 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_cnt == 16'd0) begin
          state_n    = S_STOP;
          baud_cnt_n = period_m1(baud_div);
          tx_n       = 1'b1;
        end else begin
          baud_cnt_n = baud_cnt - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (baud_cnt == 16'd0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop        = 1'b1;
            shreg_n    = fifo_mem[rd_ptr];
            state_n    = S_START;
            baud_cnt_n = period_m1(baud_div);
            tx_n       = 1'b0;
          end else begin
            state_n    = S_IDLE;
            baud_cnt_n = 16'd0;
            tx_n       = 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt - 16'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // Control state: reset applies here only.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      baud_div <= DEFAULT_DIV;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      tx_q     <= tx_n;
      irq_q    <= (count_n == '0) && (state_n == S_IDLE);
      count    <= count_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (wr_baud) baud_div <= i_st_data[15:0];
      // A new overflow in the same cycle as a clear wins.
      if (wr_status && i_st_data[3]) overflow <= 1'b0;
      if (wr_txdata && full && !pop) overflow <= 1'b1;
    end
  end

  // Datapath storage: no reset needed.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= i_st_data[7:0];
    shreg <= shreg_n;
  end

  always_comb begin
    o_ld_data = 32'd0;
    if (sel) begin
      case (off)
        2'd1:    o_ld_data = {23'd0, PARITY_FLAG, level, overflow,
                              (state != S_IDLE), empty, full};
        2'd2:    o_ld_data = {16'd0, baud_div};
        default: o_ld_data = 32'd0;
      endcase
    end
  end

  assign o_tx        = tx_q;
  assign o_irq_empty = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. Expected line waveforms and STATUS
// values come from a frame-level model: each byte becomes a list of line
// levels (start, 8 data bits LSB first, optional parity, stop), each held for
// P cycles, and FIFO level/busy are derived from push and frame-start times.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_7000;
  localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        st_en;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        tx;
  logic        irq;

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_addr      (addr),
    .i_st_en     (st_en),
    .i_st_data   (st_data),
    .o_ld_data   (ld_data),
    .o_tx        (tx),
    .o_irq_empty (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tb_bytes [16];
  int         exp_line [$];

  function automatic int eff_p(input int div);
    return (div == 0) ? 1 : div;
  endfunction

  function automatic logic [31:0] status_word(input int level, input bit busy,
                                              input bit ovf);
    logic [31:0] s;
    s = 32'd0;
    s[0]   = (level == DEPTH);
    s[1]   = (level == 0);
    s[2]   = busy;
    s[3]   = ovf;
    s[7:4] = (level > 15) ? 4'hF : 4'(level);
    s[8]   = PAR;
    return s;
  endfunction

  // Expected line level for every cycle of n back-to-back frames.
  task automatic build_stream(input int n, input int p);
    logic [7:0] b;
    exp_line.delete();
    for (int f = 0; f < n; f++) begin
      b = tb_bytes[f];
      repeat (p) exp_line.push_back(0);
      for (int k = 0; k < 8; k++) repeat (p) exp_line.push_back(int'(b[k]));
      if (PAR) repeat (p) exp_line.push_back(int'(^b));
      repeat (p) exp_line.push_back(1);
    end
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    addr = a; st_data = d; st_en = 1'b1;
    @(posedge clk); #1;
    st_en = 1'b0; st_data = 32'd0;
  endtask

  // Pushes tb_bytes[0..n-1] on consecutive cycles at divisor div and checks
  // the line every cycle plus STATUS/irq once all pushes are done.
  task automatic run_stream(input int n, input int div, input string name);
    int p, flen, expv, started, level;
    bit busy;
    logic [31:0] exps;
    write_reg(BASE + 32'h8, 32'(div));
    p = eff_p(div);
    flen = (PAR ? 11 : 10) * p;
    build_stream(n, p);
    for (int i = 0; i <= exp_line.size(); i++) begin
      if (i < n) begin
        addr = BASE; st_data = {24'd0, tb_bytes[i]}; st_en = 1'b1;
      end else begin
        st_en = 1'b0; st_data = 32'd0; addr = BASE + 32'h4;
      end
      @(posedge clk); #1;
      expv = (i == 0) ? 1 : exp_line[i-1];
      n_checks++;
      if (tx !== expv[0]) begin
        n_fail++;
        $display("FAIL %s tx cycle %0d: got %b expected %b", name, i, tx, expv[0]);
      end
      if (i >= n) begin
        started = 0;
        for (int f = 0; f < n; f++) if (1 + f * flen <= i) started++;
        level = n - started;
        busy  = (i >= 1) && (i <= n * flen);
        exps  = status_word(level, busy, 1'b0);
        n_checks++;
        if (ld_data !== exps) begin
          n_fail++;
          $display("FAIL %s status cycle %0d: got %h expected %h", name, i, ld_data, exps);
        end
        n_checks++;
        if (irq !== (!busy && level == 0)) begin
          n_fail++;
          $display("FAIL %s irq cycle %0d: got %b expected %b", name, i, irq, (!busy && level == 0));
        end
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (tx !== 1'b1) begin
      n_fail++; $display("FAIL %s idle_tx: got %b expected 1", name, tx);
    end
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL %s idle_irq: got %b expected 1", name, irq);
    end
  endtask

  task automatic test_reset;
    logic [31:0] exps;
    rst = 1'b1; st_en = 1'b0; addr = 32'd0; st_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exps = status_word(0, 1'b0, 1'b0);
    addr = BASE + 32'h4; #1;
    n_checks++;
    if (ld_data !== exps) begin n_fail++; $display("FAIL reset_status: got %h expected %h", ld_data, exps); end
    addr = BASE + 32'h8; #1;
    n_checks++;
    if (ld_data !== 32'd434) begin n_fail++; $display("FAIL reset_baud: got %0d expected 434", ld_data); end
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL reset_irq: got %b expected 1", irq); end
    addr = BASE + 32'hC; #1;
    n_checks++;
    if (ld_data !== 32'd0) begin n_fail++; $display("FAIL reserved_read: got %h expected 0", ld_data); end
    addr = BASE; #1;
    n_checks++;
    if (ld_data !== 32'd0) begin n_fail++; $display("FAIL txdata_read: got %h expected 0", ld_data); end
    addr = BASE + 32'h18; #1;
    n_checks++;
    if (ld_data !== 32'd0) begin n_fail++; $display("FAIL outside_read: got %h expected 0", ld_data); end
    // A store outside the window must not reach the FIFO.
    write_reg(32'h2000_7000, 32'hAA);
    addr = BASE + 32'h4; #1;
    n_checks++;
    if (ld_data !== exps) begin n_fail++; $display("FAIL outside_store: got %h expected %h", ld_data, exps); end
    @(posedge clk); #1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL outside_store_tx: got %b expected 1", tx); end
  endtask

  task automatic test_basic_frame;
    tb_bytes[0] = 8'h55;
    run_stream(1, 4, "basic_55");
  endtask

  task automatic test_back_to_back;
    tb_bytes[0] = 8'hA3;
    tb_bytes[1] = 8'h0F;
    run_stream(2, 2, "b2b");
  endtask

  task automatic test_zero_div;
    tb_bytes[0] = 8'hFF;
    run_stream(1, 0, "div0");
  endtask

  task automatic test_parity_byte;
    tb_bytes[0] = 8'h07;
    run_stream(1, 4, "byte07");
  endtask

  task automatic test_random;
    int n, div;
    for (int t = 0; t < 4; t++) begin
      n   = int'($urandom_range(1, 6));
      div = int'($urandom_range(0, 5));
      for (int k = 0; k < n; k++) tb_bytes[k] = 8'($urandom_range(0, 255));
      run_stream(n, div, $sformatf("rand%0d", t));
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] exps;
    write_reg(BASE + 32'h8, 32'd4);
    write_reg(BASE, 32'h00);
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL midframe_data: got %b expected 0", tx); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL midframe_reset_tx: got %b expected 1", tx); end
    rst = 1'b0;
    exps = status_word(0, 1'b0, 1'b0);
    addr = BASE + 32'h4; #1;
    n_checks++;
    if (ld_data !== exps) begin n_fail++; $display("FAIL midframe_status: got %h expected %h", ld_data, exps); end
    addr = BASE + 32'h8; #1;
    n_checks++;
    if (ld_data !== 32'd434) begin n_fail++; $display("FAIL midframe_baud: got %0d expected 434", ld_data); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL midframe_irq: got %b expected 1", irq); end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL postreset_idle cycle %0d: got %b expected 1", k, tx); end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] exps;
    int pushes, level;
    write_reg(BASE + 32'h8, 32'd1000);
    pushes = 10;
    for (int k = 0; k < pushes; k++) write_reg(BASE, 32'(k + 8'h30));
    // One byte left the FIFO for the frame in flight.
    level = (pushes - 1 > DEPTH) ? DEPTH : pushes - 1;
    exps = status_word(level, 1'b1, (pushes - 1) > DEPTH);
    addr = BASE + 32'h4; #1;
    n_checks++;
    if (ld_data !== exps) begin n_fail++; $display("FAIL overflow_status: got %h expected %h", ld_data, exps); end
    n_checks++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL overflow_start_bit: got %b expected 0", tx); end
    write_reg(BASE + 32'h4, 32'h8);
    exps = status_word(level, 1'b1, 1'b0);
    addr = BASE + 32'h4; #1;
    n_checks++;
    if (ld_data !== exps) begin n_fail++; $display("FAIL overflow_clear: got %h expected %h", ld_data, exps); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exps = status_word(0, 1'b0, 1'b0);
    n_checks++;
    if (ld_data !== exps) begin n_fail++; $display("FAIL overflow_reset: got %h expected %h", ld_data, exps); end
  endtask

  initial begin
    rst = 1'b1; st_en = 1'b0; addr = 32'd0; st_data = 32'd0;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_zero_div();
    test_parity_byte();
    test_random();
    test_reset_mid_frame();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
